// File: rtl/load_cache_arbiter_pkg.sv
// Shared definitions for the load-side cache read port arbiter.
// FSM state encodings and default sizing used by load_cache_arbiter.
package load_cache_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_STALL,
    ST_RESP
  } state_t;

  localparam int DEFAULT_WORD_SIZE = 32;
  localparam int DEFAULT_MEM_STALL = 4;
  localparam int STALL_CNT_W       = 8;

endpackage

// File: rtl/load_cache_arbiter_rr_picker.sv
// Combinational round-robin picker: finds the first set request bit at or after ptr,
// wrapping modulo N. Kept generic so it can also arbitrate the CDB.
module load_cache_arbiter_rr_picker #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      logic [IW-1:0] cand;
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/load_cache_arbiter.sv
// Shares the data-cache read port among LOADER_NUM load reservation stations.
// Optional hit/miss statistics outputs are enabled with LOAD_ARB_STATS_EN.
module load_cache_arbiter
  import load_cache_arbiter_pkg::*;
#(
  parameter int LOADER_NUM       = 4,
  parameter int WORD_SIZE        = DEFAULT_WORD_SIZE,
  parameter int LDR_INDEX        = 2,
  parameter int MEM_STALL_CYCLES = DEFAULT_MEM_STALL
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [LOADER_NUM-1:0]           req_bus,
  input  logic [LOADER_NUM*WORD_SIZE-1:0] req_addr_bus,
  input  logic [LOADER_NUM-1:0]           cancel_bus,
  output logic [LOADER_NUM-1:0]           resp_valid_bus,
  output logic [WORD_SIZE-1:0]            resp_data,
  output logic [WORD_SIZE-1:0]            c_ptr,
  output logic                            c_read_enable,
  input  logic [WORD_SIZE-1:0]            c_out,
  input  logic                            c_hit
`ifdef LOAD_ARB_STATS_EN
  ,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
`endif
);

  localparam logic [STALL_CNT_W-1:0] STALL_INIT = STALL_CNT_W'(MEM_STALL_CYCLES);

  state_t                   state_q, state_d;
  logic [LDR_INDEX-1:0]     rr_ptr_q, rr_ptr_d;
  logic [LDR_INDEX-1:0]     gnt_q, gnt_d;
  logic [WORD_SIZE-1:0]     c_ptr_q, c_ptr_d;
  logic                     c_rd_en_q, c_rd_en_d;
  logic [LOADER_NUM-1:0]    resp_valid_q, resp_valid_d;
  logic [WORD_SIZE-1:0]     resp_data_q, resp_data_d;
  logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                     cancelled_q, cancelled_d;

  logic                     pick_found;
  logic [LDR_INDEX-1:0]     pick_idx;
  logic [WORD_SIZE-1:0]     pick_addr;
  logic                     cancel_seen;
  logic                     data_ready;
  logic [LOADER_NUM-1:0]    gnt_onehot;

  load_cache_arbiter_rr_picker #(
    .N  (LOADER_NUM),
    .IW (LDR_INDEX)
  ) u_picker (
    .req   (req_bus & ~cancel_bus),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < LOADER_NUM; i++) begin
      if (LDR_INDEX'(i) == pick_idx) pick_addr = req_addr_bus[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  assign cancel_seen = cancelled_q | cancel_bus[gnt_q];
  assign gnt_onehot  = LOADER_NUM'(1) << gnt_q;
  assign data_ready  = (state_q == ST_LOOKUP && c_hit) ||
                       (state_q == ST_STALL && stall_cnt_q <= STALL_CNT_W'(1));

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    gnt_d        = gnt_q;
    c_ptr_d      = c_ptr_q;
    c_rd_en_d    = c_rd_en_q;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    stall_cnt_d  = stall_cnt_q;
    cancelled_d  = cancelled_q;
    case (state_q)
      ST_IDLE: begin
        c_rd_en_d   = 1'b0;
        cancelled_d = 1'b0;
        if (pick_found) begin
          gnt_d     = pick_idx;
          c_ptr_d   = pick_addr;
          c_rd_en_d = 1'b1;
          state_d   = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        cancelled_d = cancel_seen;
        if (!c_hit) begin
          stall_cnt_d = STALL_INIT;
          state_d     = ST_STALL;
        end
      end
      ST_STALL: begin
        cancelled_d = cancel_seen;
        stall_cnt_d = stall_cnt_q - STALL_CNT_W'(1);
      end
      ST_RESP: begin
        cancelled_d = 1'b0;
        rr_ptr_d    = (gnt_q == LDR_INDEX'(LOADER_NUM - 1)) ? '0 : gnt_q + 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Data arrives either straight from a hit or at the end of the miss wait.
    if (data_ready) begin
      resp_data_d  = c_out;
      c_rd_en_d    = 1'b0;
      resp_valid_d = cancel_seen ? '0 : gnt_onehot;
      state_d      = ST_RESP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      c_ptr_q      <= '0;
      c_rd_en_q    <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      stall_cnt_q  <= '0;
      cancelled_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      c_ptr_q      <= c_ptr_d;
      c_rd_en_q    <= c_rd_en_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      stall_cnt_q  <= stall_cnt_d;
      cancelled_q  <= cancelled_d;
    end
  end

  // A flush landing in the response cycle itself still suppresses the pulse.
  assign resp_valid_bus = resp_valid_q & ~cancel_bus;
  assign resp_data      = resp_data_q;
  assign c_ptr          = c_ptr_q;
  assign c_read_enable  = c_rd_en_q;

`ifdef LOAD_ARB_STATS_EN
  logic [15:0] hit_count_q, hit_count_d;
  logic [15:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == ST_LOOKUP) begin
      if (c_hit && hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
      if (!c_hit && miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_load_cache_arbiter.sv
// Self-checking bench for load_cache_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_load_cache_arbiter;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int STALL = 4;

  logic           clk = 1'b0;
  logic           reset_n = 1'b1;
  logic [N-1:0]   req_bus = '0;
  logic [N*W-1:0] req_addr_bus = '0;
  logic [N-1:0]   cancel_bus = '0;
  logic [N-1:0]   resp_valid_bus;
  logic [W-1:0]   resp_data;
  logic [W-1:0]   c_ptr;
  logic           c_read_enable;
  logic [W-1:0]   c_out = '0;
  logic           c_hit = 1'b0;
`ifdef LOAD_ARB_STATS_EN
  logic [15:0]    hit_count;
  logic [15:0]    miss_count;
`endif

  int errors = 0;
  int checks = 0;
  int model_ptr = 0;
  logic [W-1:0] addr_m [N];

  load_cache_arbiter #(
    .LOADER_NUM       (N),
    .WORD_SIZE        (W),
    .LDR_INDEX        (2),
    .MEM_STALL_CYCLES (STALL)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_bus        (req_bus),
    .req_addr_bus   (req_addr_bus),
    .cancel_bus     (cancel_bus),
    .resp_valid_bus (resp_valid_bus),
    .resp_data      (resp_data),
    .c_ptr          (c_ptr),
    .c_read_enable  (c_read_enable),
    .c_out          (c_out),
    .c_hit          (c_hit)
`ifdef LOAD_ARB_STATS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_addrs();
    for (int i = 0; i < N; i++) req_addr_bus[i*W +: W] = addr_m[i];
  endtask

  task automatic do_reset();
    req_bus    = '0;
    cancel_bus = '0;
    c_hit      = 1'b0;
    c_out      = '0;
    reset_n    = 1'b0;
    step();
    reset_n    = 1'b1;
    model_ptr  = 0;
  endtask

  task automatic test_reset();
    step();
    req_bus = '1;
    for (int i = 0; i < N; i++) addr_m[i] = 32'h1000 + 32'(i);
    drive_addrs();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (resp_valid_bus !== '0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b exp 0", resp_valid_bus); end
    checks++; if (resp_data !== '0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h exp 0", resp_data); end
    checks++; if (c_ptr !== '0) begin errors++; $display("[TB] FAIL reset_c_ptr: got %h exp 0", c_ptr); end
    checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL reset_c_read_enable: got %b exp 0", c_read_enable); end
    req_bus = '0;
    reset_n = 1'b1;
    model_ptr = 0;
    step();
  endtask

  task automatic test_single_hit();
    do_reset();
    addr_m[2] = 32'h40;
    drive_addrs();
    req_bus = 4'b0100;
    step();
    checks++; if (c_ptr !== 32'h40) begin errors++; $display("[TB] FAIL hit_c_ptr: got %h exp %h", c_ptr, 32'h40); end
    checks++; if (c_read_enable !== 1'b1) begin errors++; $display("[TB] FAIL hit_c_read_enable: got %b exp 1", c_read_enable); end
    c_hit = 1'b1;
    c_out = 32'h1234;
    step();
    checks++; if (resp_valid_bus !== 4'b0100) begin errors++; $display("[TB] FAIL hit_resp_valid: got %b exp 0100", resp_valid_bus); end
    checks++; if (resp_data !== 32'h1234) begin errors++; $display("[TB] FAIL hit_resp_data: got %h exp 1234", resp_data); end
    checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL hit_enable_drop: got %b exp 0", c_read_enable); end
    req_bus = '0;
    c_hit   = 1'b0;
    c_out   = '0;
    step();
    checks++; if (resp_valid_bus !== '0) begin errors++; $display("[TB] FAIL hit_pulse_width: got %b exp 0", resp_valid_bus); end
  endtask

  task automatic test_miss();
    int cycles;
    do_reset();
    addr_m[0] = 32'h80;
    drive_addrs();
    req_bus = 4'b0001;
    step();
    checks++; if (c_ptr !== 32'h80) begin errors++; $display("[TB] FAIL miss_c_ptr: got %h exp 80", c_ptr); end
    c_hit = 1'b0;
    c_out = 32'hBEEF;
    cycles = 1;
    while (resp_valid_bus === '0 && cycles < 20) begin
      checks++; if (c_read_enable !== 1'b1) begin errors++; $display("[TB] FAIL miss_enable_held: got %b exp 1 at cycle %0d", c_read_enable, cycles); end
      step();
      cycles++;
    end
    checks++; if (cycles != 2 + STALL) begin errors++; $display("[TB] FAIL miss_latency: got %0d exp %0d", cycles, 2 + STALL); end
    checks++; if (resp_valid_bus !== 4'b0001) begin errors++; $display("[TB] FAIL miss_resp_valid: got %b exp 0001", resp_valid_bus); end
    checks++; if (resp_data !== 32'hBEEF) begin errors++; $display("[TB] FAIL miss_resp_data: got %h exp beef", resp_data); end
    req_bus = '0;
    step();
  endtask

  task automatic test_round_robin();
    logic [W-1:0] d;
    int exp;
    do_reset();
    for (int i = 0; i < N; i++) addr_m[i] = $urandom;
    drive_addrs();
    req_bus = '1;
    c_hit = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp = g % N;
      step();
      checks++; if (c_ptr !== addr_m[exp]) begin errors++; $display("[TB] FAIL rr_grant%0d_c_ptr: got %h exp %h", g, c_ptr, addr_m[exp]); end
      d = $urandom;
      c_out = d;
      step();
      checks++; if (resp_valid_bus !== N'(1 << exp)) begin errors++; $display("[TB] FAIL rr_grant%0d_resp_valid: got %b exp %b", g, resp_valid_bus, N'(1 << exp)); end
      checks++; if (resp_data !== d) begin errors++; $display("[TB] FAIL rr_grant%0d_resp_data: got %h exp %h", g, resp_data, d); end
      if (g == 4) req_bus = '0;
      step();
    end
    c_hit = 1'b0;
  endtask

  task automatic test_cancel();
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < N; i++) addr_m[i] = $urandom;
    drive_addrs();
    // Loader 1 granted, then flushed during LOOKUP.
    req_bus = 4'b0110;
    step();
    checks++; if (c_ptr !== addr_m[1]) begin errors++; $display("[TB] FAIL cancel_grant1_c_ptr: got %h exp %h", c_ptr, addr_m[1]); end
    cancel_bus = 4'b0010;
    c_hit = 1'b1;
    c_out = $urandom;
    step();
    cancel_bus = '0;
    req_bus = 4'b0100;
    checks++; if (resp_valid_bus !== '0) begin errors++; $display("[TB] FAIL cancel_lookup_resp: got %b exp 0", resp_valid_bus); end
    checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL cancel_lookup_completes: got %b exp 0", c_read_enable); end
    step();
    step();
    checks++; if (c_ptr !== addr_m[2]) begin errors++; $display("[TB] FAIL cancel_next_grant: got %h exp %h", c_ptr, addr_m[2]); end
    d = $urandom;
    c_out = d;
    step();
    checks++; if (resp_valid_bus !== 4'b0100) begin errors++; $display("[TB] FAIL cancel_next_resp: got %b exp 0100", resp_valid_bus); end
    checks++; if (resp_data !== d) begin errors++; $display("[TB] FAIL cancel_next_data: got %h exp %h", resp_data, d); end
    req_bus = '0;
    step();
    // Loader 3 flushed mid-stall: transaction runs to the end, no pulse.
    req_bus = 4'b1000;
    step();
    c_hit = 1'b0;
    step();
    cancel_bus = 4'b1000;
    step();
    cancel_bus = '0;
    req_bus = '0;
    for (int s = 0; s < STALL - 1; s++) step();
    checks++; if (resp_valid_bus !== '0) begin errors++; $display("[TB] FAIL cancel_stall_resp: got %b exp 0", resp_valid_bus); end
    checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL cancel_stall_completes: got %b exp 0", c_read_enable); end
    step();
    // Request and cancel together in IDLE: no grant.
    req_bus = 4'b0001;
    cancel_bus = 4'b0001;
    step();
    checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL cancel_idle_no_grant: got %b exp 0", c_read_enable); end
    cancel_bus = '0;
    step();
    checks++; if (c_read_enable !== 1'b1 || c_ptr !== addr_m[0]) begin errors++; $display("[TB] FAIL cancel_idle_later_grant: got en=%b ptr=%h exp en=1 ptr=%h", c_read_enable, c_ptr, addr_m[0]); end
    c_hit = 1'b1;
    step();
    checks++; if (resp_valid_bus !== 4'b0001) begin errors++; $display("[TB] FAIL cancel_idle_later_resp: got %b exp 0001", resp_valid_bus); end
    req_bus = '0;
    c_hit = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_stall();
    logic [W-1:0] d;
    do_reset();
    for (int i = 0; i < N; i++) addr_m[i] = $urandom | 32'h1;
    drive_addrs();
    req_bus = 4'b0001;
    step();
    c_hit = 1'b0;
    c_out = $urandom;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall_enable: got %b exp 0", c_read_enable); end
    checks++; if (c_ptr !== '0) begin errors++; $display("[TB] FAIL rst_stall_c_ptr: got %h exp 0", c_ptr); end
    checks++; if (resp_valid_bus !== '0 || resp_data !== '0) begin errors++; $display("[TB] FAIL rst_stall_resp: got %b/%h exp 0/0", resp_valid_bus, resp_data); end
    step();
    reset_n = 1'b1;
    req_bus = 4'b1000;
    c_hit = 1'b1;
    d = $urandom;
    c_out = d;
    step();
    checks++; if (c_read_enable !== 1'b1 || c_ptr !== addr_m[3]) begin errors++; $display("[TB] FAIL rst_fresh_grant: got en=%b ptr=%h exp en=1 ptr=%h", c_read_enable, c_ptr, addr_m[3]); end
    step();
    checks++; if (resp_valid_bus !== 4'b1000 || resp_data !== d) begin errors++; $display("[TB] FAIL rst_fresh_resp: got %b/%h exp 1000/%h", resp_valid_bus, resp_data, d); end
    req_bus = '0;
    c_hit = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [N-1:0] pending;
    logic [N-1:0] fresh;
    logic [W-1:0] d;
    logic [W-1:0] granted_addr;
    logic         hit;
    int exp;
    do_reset();
    pending = '0;
    for (int it = 0; it < 60; it++) begin
      fresh = N'($urandom) & ~pending;
      for (int i = 0; i < N; i++) if (fresh[i]) addr_m[i] = $urandom;
      pending = pending | fresh;
      drive_addrs();
      req_bus = pending;
      if (pending == '0) begin
        step();
        checks++; if (c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle_it%0d: got en=%b exp 0", it, c_read_enable); end
        continue;
      end
      // Expected grant: first pending loader at or after the pointer, wrapping.
      exp = -1;
      for (int k = 0; k < N; k++) if (exp < 0 && pending[(model_ptr + k) % N]) exp = (model_ptr + k) % N;
      granted_addr = addr_m[exp];
      step();
      checks++; if (c_read_enable !== 1'b1 || c_ptr !== granted_addr) begin errors++; $display("[TB] FAIL rand_grant_it%0d: got en=%b ptr=%h exp en=1 ptr=%h (loader %0d)", it, c_read_enable, c_ptr, granted_addr, exp); end
      addr_m[exp] = $urandom;
      drive_addrs();
      hit = 1'($urandom);
      d = $urandom;
      c_hit = hit;
      c_out = hit ? d : $urandom;
      step();
      if (!hit) begin
        for (int s = 1; s <= STALL; s++) begin
          c_hit = 1'($urandom);
          c_out = (s == STALL) ? d : $urandom;
          checks++; if (c_read_enable !== 1'b1 || resp_valid_bus !== '0 || c_ptr !== granted_addr) begin errors++; $display("[TB] FAIL rand_stall_it%0d_s%0d: got en=%b rv=%b ptr=%h exp en=1 rv=0 ptr=%h", it, s, c_read_enable, resp_valid_bus, c_ptr, granted_addr); end
          step();
        end
      end
      checks++; if (resp_valid_bus !== N'(1 << exp) || resp_data !== d || c_read_enable !== 1'b0) begin errors++; $display("[TB] FAIL rand_resp_it%0d: got rv=%b data=%h en=%b exp rv=%b data=%h en=0", it, resp_valid_bus, resp_data, c_read_enable, N'(1 << exp), d); end
      pending[exp] = 1'b0;
      model_ptr = (exp + 1) % N;
      req_bus = pending;
      c_hit = 1'b0;
      step();
    end
    req_bus = '0;
  endtask

`ifdef LOAD_ARB_STATS_EN
  task automatic test_stats();
    logic h;
    do_reset();
    checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("[TB] FAIL stats_reset: got %0d/%0d exp 0/0", hit_count, miss_count); end
    for (int t = 0; t < 5; t++) begin
      h = (t % 2 == 0);
      req_bus = N'(1 << (t % N));
      step();
      c_hit = h;
      c_out = $urandom;
      step();
      if (!h) for (int s = 0; s < STALL; s++) step();
      req_bus = '0;
      c_hit = 1'b0;
      step();
    end
    checks++; if (hit_count !== 16'd3) begin errors++; $display("[TB] FAIL stats_hits: got %0d exp 3", hit_count); end
    checks++; if (miss_count !== 16'd2) begin errors++; $display("[TB] FAIL stats_misses: got %0d exp 2", miss_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_miss();
    test_round_robin();
    test_cancel();
    test_reset_mid_stall();
    test_random();
`ifdef LOAD_ARB_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_cache_arbiter.md
Name: load_cache_arbiter

Overview:
- Shares the single data-cache read port among LOADER_NUM load reservation stations.
- Each loader raises a request with an address and waits. The arbiter grants one requester at a time in round-robin order, drives the cache, and waits out a miss stall.
- It then returns the data to the granted loader with a one-cycle valid pulse.
- Sits between the load RS bank and the cache, replacing direct per-loader wiring of the cache read controls.

Parameters:
- LOADER_NUM, 4, number of load reservation stations sharing the port.
- WORD_SIZE, 32, address/data width.
- LDR_INDEX, 2, width of a loader index; equals clog2(LOADER_NUM).
- MEM_STALL_CYCLES, 4, extra cycles waited after a miss before data is sampled; legal range 1 to 255.

Ports:
- clk  in  1  clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_bus  in  LOADER_NUM  per-loader read request; loader i uses bit i.
- req_addr_bus  in  LOADER_NUM*WORD_SIZE  per-loader address; loader i uses bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE].
- cancel_bus  in  LOADER_NUM  per-loader flush, driven from the RS reset bus.
- resp_valid_bus  out  LOADER_NUM  one-hot, one-cycle pulse: data ready for loader i.
- resp_data  out  WORD_SIZE  returned word; meaningful only while resp_valid_bus is nonzero.
- c_ptr  out  WORD_SIZE  cache read address.
- c_read_enable  out  1  cache read strobe.
- c_out  in  WORD_SIZE  cache read data.
- c_hit  in  1  cache hit flag; valid one cycle after c_read_enable rises.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=IDLE, rr_ptr=0.
  - resp_valid_bus=0, resp_data=0, c_ptr=0, c_read_enable=0.
  - stall counter=0, cancelled flag=0.
- IDLE:
  - Search req_bus & ~cancel_bus starting at rr_ptr, wrapping modulo LOADER_NUM.
  - If a requester is found: latch its index as gnt and its address into c_ptr, set c_read_enable=1, go to LOOKUP.
  - If none is found: stay in IDLE with c_read_enable=0.
- LOOKUP (one cycle after the grant):
  - If c_hit=1: register c_out into a data register, go to RESP.
  - If c_hit=0: load the stall counter with MEM_STALL_CYCLES, go to STALL.
- STALL:
  - Decrement the counter each cycle.
  - When the counter reaches 1: register c_out, go to RESP.
  - c_read_enable and c_ptr stay held throughout STALL.
- RESP (exactly one cycle):
  - c_read_enable=0.
  - resp_data = registered data.
  - resp_valid_bus = 1<<gnt, unless the cancelled flag is set, in which case it is 0.
  - rr_ptr = (gnt+1) mod LOADER_NUM; go to IDLE.
  - Clear the cancelled flag.
- Latency, from grant to response:
  - Hit: grant cycle, LOOKUP, then RESP pulse (3 cycles).
  - Miss: adds MEM_STALL_CYCLES cycles.
- Back-to-back: a new grant may be issued in the IDLE cycle immediately after RESP. The minimum spacing between grants is 3 cycles.
- Requester rules:
  - A loader holds req and its address stable until it sees its resp_valid bit.
  - A loader drops req in the cycle after its response.
  - Address changes while a grant is in flight are ignored, because the address is latched at grant.
- Cancel:
  - If cancel_bus[gnt] is asserted in any cycle from LOOKUP through RESP, set the cancelled flag.
  - The cache transaction still completes normally; only the response pulse is suppressed.
  - A cancelled loader is never granted in the same cycle its cancel is high.
- Fairness: with all loaders requesting continuously, grants rotate 0,1,...,LOADER_NUM-1,0.
- Simultaneous events:
  - Req and cancel on the same loader in IDLE: the loader is not granted.
  - Asynchronous reset mid-transaction: aborts immediately, no response is emitted, c_read_enable drops at once.

Optional Feature:
- Macro: LOAD_ARB_STATS_EN.
- When defined:
  - Adds outputs hit_count (16 bits) and miss_count (16 bits).
  - Each counter increments in LOOKUP according to c_hit, including for cancelled transactions.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package/include (parameters.v): state encodings ST_IDLE, ST_LOOKUP, ST_STALL, ST_RESP; WORD_SIZE; MEM_STALL default.
- One sub-module: rr_picker.
  - Purely combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: found flag and index.
  - Reusable for CDB arbitration.

Test Plan:
- Single hit: loader 2 requests addr 0x40, c_hit=1, c_out=0x1234 on the cycle after the grant -> c_ptr=0x40; resp_valid_bus=4'b0100 and resp_data=0x1234 exactly 2 cycles after the grant; c_read_enable drops in RESP.
- Miss: loader 0 requests addr 0x80 with c_hit=0 and MEM_STALL_CYCLES=4, c_out=0xBEEF -> response for loader 0 arrives 6 cycles after the grant with data 0xBEEF; c_read_enable is held high through STALL.
- Round robin: all four loaders request continuously with hits -> grant order is 0,1,2,3,0; each response pulses only its own bit.
- Cancel in flight: loader 1 is granted, then cancel_bus[1] is pulsed during LOOKUP -> no resp_valid pulse; the next grant goes to loader 2 if it is requesting.
- Reset mid-stall: reset_n is dropped during STALL -> all outputs are 0 immediately; after release, a fresh request from loader 3 is granted first (rr_ptr=0 search order, loader 3 being the only requester).
- Stats (with LOAD_ARB_STATS_EN): 3 hits and 2 misses -> hit_count=3, miss_count=2.
